rf_frame_receiver: RTL

- Consumes the serial bit stream and per-bit error flag produced by the Manchester decoder stage, one bit per strobe.
- Hunts for a sync word, then deserializes a length byte, the payload bytes and a trailing CRC-8.
- Delivers payload bytes with a one-cycle valid pulse and reports frame status (start, done, CRC result, abort) to the packet consumer.

---
 rtl/rf_frame_receiver_if.sv | 49 ++++
 rtl/rf_frame_receiver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/rf_frame_receiver_if.sv
// rf_frame_receiver_if
//
// Purpose: bundles the receiver's bit-stream input (from the Manchester
// decoder stage) and its frame/payload outputs (to the packet consumer)
// into one interface. clk and rst_n stay plain ports on the receiver.
//
// Signals:
//   enable       receiver enable; low forces the receiver idle
//   bit_valid    one-cycle strobe, bit_in/bit_err valid this cycle
//   bit_in       decoded data bit, MSB first
//   bit_err      decoder error / loss-of-sync for this bit
//   frame_start  one-cycle pulse, sync word matched
//   frame_len    received length byte
//   data_out     payload byte
//   data_valid   one-cycle pulse per payload byte
//   frame_done   one-cycle pulse after the last CRC bit
//   crc_ok       CRC comparison result
//   frame_err    one-cycle pulse on frame abort
//   busy         high whenever the receiver is not hunting for sync
//
// Modports:
//   master  the side that drives the bit stream and consumes frame status
//   slave   the receiver itself
interface rf_frame_receiver_if;
  logic       enable;
  logic       bit_valid;
  logic       bit_in;
  logic       bit_err;
  logic       frame_start;
  logic [7:0] frame_len;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_done;
  logic       crc_ok;
  logic       frame_err;
  logic       busy;

  modport master (
    output enable, bit_valid, bit_in, bit_err,
    input  frame_start, frame_len, data_out, data_valid,
           frame_done, crc_ok, frame_err, busy
  );

  modport slave (
    input  enable, bit_valid, bit_in, bit_err,
    output frame_start, frame_len, data_out, data_valid,
           frame_done, crc_ok, frame_err, busy
  );
endinterface

// File: rtl/rf_frame_receiver.sv
// rf_frame_receiver
//
// Purpose: takes the serial bit stream from the Manchester decoder, hunts
// for a sync word, then deserializes a length byte, that many payload bytes
// and a trailing CRC-8 (poly 0x07, init 0x00, no reflection, no final XOR,
// covering the length byte and the payload). Payload bytes are delivered
// with a one-cycle data_valid pulse; frame status is reported as pulses.
//
// Ports:
//   clk    clock, all logic on its rising edge
//   rst_n  synchronous reset, active low
//   rx     rf_frame_receiver_if.slave (bit stream in, frame status out)
//
// Parameters:
//   SYNC_WORD  sync pattern, MSB received first
//   SYNC_LEN   number of low SYNC_WORD bits compared (1..16)
//   MAX_LEN    largest legal payload length in bytes (1..255)
//
// Build option:
//   FRAME_SYNC_TOL_EN  when defined, the sync match tolerates one mismatched
//                      bit among the compared bits. Undefined (default):
//                      exact match only.
module rf_frame_receiver #(
  parameter logic [15:0] SYNC_WORD = 16'h2DD4,
  parameter int          SYNC_LEN  = 16,
  parameter int          MAX_LEN   = 32
) (
  input logic            clk,
  input logic            rst_n,
  rf_frame_receiver_if.slave rx
);

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CRC
  } state_t;

  localparam logic [4:0]  SYNC_LEN_W  = 5'(SYNC_LEN);
  localparam logic [7:0]  MAX_LEN_B   = 8'(MAX_LEN);
  localparam logic [16:0] SYNC_MASK_W = (17'd1 << SYNC_LEN) - 17'd1;
  localparam logic [15:0] SYNC_MASK   = SYNC_MASK_W[15:0];
  localparam logic [4:0]  FILL_MAX    = 5'd16;

  state_t      state;
  logic [15:0] sync_reg;
  logic [4:0]  fill;
  logic [7:0]  crc;
  logic [7:0]  shift;
  logic [2:0]  bit_cnt;
  logic [7:0]  byte_cnt;

  logic        frame_start_q;
  logic [7:0]  frame_len_q;
  logic [7:0]  data_out_q;
  logic        data_valid_q;
  logic        frame_done_q;
  logic        crc_ok_q;
  logic        frame_err_q;

  logic [15:0] sync_next;
  logic [4:0]  fill_next;
  logic [15:0] sync_diff;
  logic        sync_hit;
  logic [7:0]  byte_next;
  logic [7:0]  crc_next;

`ifdef FRAME_SYNC_TOL_EN
  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = 5'd0;
    for (int i = 0; i < 16; i++) begin
      c = c + {4'd0, v[i]};
    end
    return c;
  endfunction
`endif

  // Everything here looks at "what the registers would hold if the current
  // bit were accepted", so the match and the byte/CRC completion decisions
  // can be taken on the same edge that consumes the bit.
  always_comb begin
    sync_next = {sync_reg[14:0], rx.bit_in};
    fill_next = (fill == FILL_MAX) ? fill : fill + 5'd1;
    sync_diff = (sync_next ^ SYNC_WORD) & SYNC_MASK;
`ifdef FRAME_SYNC_TOL_EN
    sync_hit  = (fill_next >= SYNC_LEN_W) && (popcount16(sync_diff) <= 5'd1);
`else
    sync_hit  = (fill_next >= SYNC_LEN_W) && (sync_diff == 16'd0);
`endif
    byte_next = {shift[6:0], rx.bit_in};
    crc_next  = {crc[6:0], 1'b0} ^ ((crc[7] ^ rx.bit_in) ? 8'h07 : 8'h00);
  end

  // Receiver FSM with all outputs registered. Pulses default low every
  // cycle and are only raised on an edge that consumed a bit_valid.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= HUNT;
      sync_reg      <= 16'd0;
      fill          <= 5'd0;
      crc           <= 8'd0;
      shift         <= 8'd0;
      bit_cnt       <= 3'd0;
      byte_cnt      <= 8'd0;
      frame_start_q <= 1'b0;
      frame_len_q   <= 8'd0;
      data_out_q    <= 8'd0;
      data_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      crc_ok_q      <= 1'b0;
      frame_err_q   <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      data_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_err_q   <= 1'b0;

      if (!rx.enable) begin
        // Quiet abort: clear the datapath but keep the last reported
        // frame_len / data_out / crc_ok for the consumer.
        state    <= HUNT;
        sync_reg <= 16'd0;
        fill     <= 5'd0;
        crc      <= 8'd0;
        shift    <= 8'd0;
        bit_cnt  <= 3'd0;
        byte_cnt <= 8'd0;
      end else if (rx.bit_valid) begin
        if (state != HUNT && rx.bit_err) begin
          // Bit error inside a frame: drop the bit and the frame.
          frame_err_q <= 1'b1;
          state       <= HUNT;
          sync_reg    <= 16'd0;
          fill        <= 5'd0;
          bit_cnt     <= 3'd0;
        end else begin
          case (state)
            HUNT: begin
              if (rx.bit_err) begin
                sync_reg <= 16'd0;
                fill     <= 5'd0;
              end else if (sync_hit) begin
                // Sync register is cleared here so the next hunt starts
                // fresh and never overlaps this frame's bits.
                frame_start_q <= 1'b1;
                state         <= LEN;
                crc           <= 8'd0;
                shift         <= 8'd0;
                bit_cnt       <= 3'd0;
                crc_ok_q      <= 1'b0;
                sync_reg      <= 16'd0;
                fill          <= 5'd0;
              end else begin
                sync_reg <= sync_next;
                fill     <= fill_next;
              end
            end

            LEN: begin
              shift   <= byte_next;
              crc     <= crc_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                frame_len_q <= byte_next;
                if (byte_next > MAX_LEN_B) begin
                  frame_err_q <= 1'b1;
                  state       <= HUNT;
                end else if (byte_next == 8'd0) begin
                  state <= CRC;
                end else begin
                  state    <= PAYLOAD;
                  byte_cnt <= byte_next;
                end
              end
            end

            PAYLOAD: begin
              shift   <= byte_next;
              crc     <= crc_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                data_out_q   <= byte_next;
                data_valid_q <= 1'b1;
                byte_cnt     <= byte_cnt - 8'd1;
                if (byte_cnt == 8'd1) begin
                  state <= CRC;
                end
              end
            end

            CRC: begin
              // The received CRC byte is not folded into the running CRC;
              // it is compared against it once complete.
              shift   <= byte_next;
              bit_cnt <= bit_cnt + 3'd1;
              if (bit_cnt == 3'd7) begin
                frame_done_q <= 1'b1;
                crc_ok_q     <= (byte_next == crc);
                state        <= HUNT;
              end
            end

            default: begin
              state <= HUNT;
            end
          endcase
        end
      end
    end
  end

  assign rx.frame_start = frame_start_q;
  assign rx.frame_len   = frame_len_q;
  assign rx.data_out    = data_out_q;
  assign rx.data_valid  = data_valid_q;
  assign rx.frame_done  = frame_done_q;
  assign rx.crc_ok      = crc_ok_q;
  assign rx.frame_err   = frame_err_q;
  assign rx.busy        = (state != HUNT);

endmodule
